// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with iterative low-word multiply and EX/MEM result register
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ValidE,
  input  logic [3:0]       ALUControlE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             StallM,
  input  logic             FlushE,
  output logic             BusyE,
  output logic [WIDTH-1:0] ALUOutM,
  output logic             ZeroM,
  output logic             ValidM,
  output logic             IllegalOpM
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] op_a, op_b, acc, op_a_n, op_b_n, acc_n, res, step_add, alu_n;
  logic [CW-1:0] cnt, cnt_n;
  logic is_mul, legal, zero_n, valid_n, illegal_n;
  assign is_mul = ALUControlE == 4'b1000;
  assign legal = ALUControlE inside {4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1000};
  assign step_add = op_b[0] ? op_a : '0;
  // single-cycle result; illegal codes yield zero
  always_comb
    res = ALUControlE == 4'b0010 ? SrcAE + SrcBE :
          ALUControlE == 4'b0110 ? SrcAE - SrcBE :
          ALUControlE == 4'b0000 ? SrcAE & SrcBE :
          ALUControlE == 4'b0001 ? SrcAE | SrcBE :
          ALUControlE == 4'b0111 ? {{(WIDTH-1){1'b0}}, $signed(SrcAE) < $signed(SrcBE)} : '0;
  // next state, multiply datapath, M-register next values and busy
  always_comb begin
    state_n = state;
    op_a_n = op_a;
    op_b_n = op_b;
    acc_n = acc;
    cnt_n = cnt;
    alu_n = ALUOutM;
    zero_n = ZeroM;
    valid_n = ValidM;
    illegal_n = IllegalOpM;
    BusyE = 1'b0;
    if (state == IDLE) begin
      BusyE = ValidE & is_mul & ~FlushE;
      if (!StallM) begin
        valid_n = 1'b0;
        if (ValidE && !FlushE && is_mul) begin
          op_a_n = SrcAE;
          op_b_n = SrcBE;
          acc_n = '0;
          cnt_n = CW'(WIDTH);
          state_n = MUL;
        end else if (ValidE && !FlushE) begin
          alu_n = res;
          zero_n = res == '0;
          illegal_n = ~legal;
          valid_n = 1'b1;
        end
      end
    end else begin
      BusyE = cnt != CW'(1) || StallM;
      if (FlushE) begin
        state_n = IDLE;
        cnt_n = '0;
        valid_n = StallM ? ValidM : 1'b0;
      end else if (cnt != CW'(1)) begin
        acc_n = acc + step_add;
        op_a_n = op_a << 1;
        op_b_n = op_b >> 1;
        cnt_n = cnt - CW'(1);
        valid_n = StallM ? ValidM : 1'b0;
      end else if (!StallM) begin
        alu_n = acc + step_add;
        zero_n = alu_n == '0;
        illegal_n = 1'b0;
        valid_n = 1'b1;
        cnt_n = '0;
        state_n = IDLE;
      end
    end
  end
  // state, multiply registers and EX/MEM result register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      op_a <= '0;
      op_b <= '0;
      ALUOutM <= '0;
      ZeroM <= 1'b0;
      ValidM <= 1'b0;
      IllegalOpM <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      acc <= acc_n;
      op_a <= op_a_n;
      op_b <= op_b_n;
      ALUOutM <= alu_n;
      ZeroM <= zero_n;
      ValidM <= valid_n;
      IllegalOpM <= illegal_n;
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors against an arithmetic reference model of the EX unit
module tb_alu_exec_unit;
  localparam int W = 32;
  logic clk = 0, rst = 1, ValidE = 0, StallM = 0, FlushE = 0;
  logic [3:0] ALUControlE = 0;
  logic [W-1:0] SrcAE = 0, SrcBE = 0;
  logic BusyE, ZeroM, ValidM, IllegalOpM;
  logic [W-1:0] ALUOutM;
  int checks = 0, failures = 0;
  bit started = 0;
  bit m_mul = 0, m_zero = 0, m_valid = 0, m_ill = 0;
  int m_k = 0;
  logic [W-1:0] m_prod = 0, m_out = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ValidE(ValidE), .ALUControlE(ALUControlE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .StallM(StallM), .FlushE(FlushE),
    .BusyE(BusyE), .ALUOutM(ALUOutM), .ZeroM(ZeroM), .ValidM(ValidM),
    .IllegalOpM(IllegalOpM)
  );

  function automatic logic [W-1:0] ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0111: return ($signed(a) < $signed(b)) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [3:0] op);
    return op inside {4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1000};
  endfunction

  task automatic chk(input string n, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endtask

  // reference model: a multiply is a W-cycle wait followed by the plain product
  always @(posedge clk) begin
    if (rst) begin
      m_mul <= 0; m_k <= 0; m_out <= 0; m_zero <= 0; m_valid <= 0; m_ill <= 0;
    end else if (m_mul) begin
      if (FlushE) begin
        m_mul <= 0;
        if (!StallM) m_valid <= 0;
      end else if (m_k > 1) begin
        m_k <= m_k - 1;
        if (!StallM) m_valid <= 0;
      end else if (!StallM) begin
        m_out <= m_prod; m_zero <= m_prod == 0; m_ill <= 0; m_valid <= 1; m_mul <= 0;
      end
    end else if (!StallM) begin
      m_valid <= 0;
      if (ValidE && !FlushE) begin
        if (ALUControlE == 4'b1000) begin
          m_mul <= 1; m_k <= W; m_prod <= SrcAE * SrcBE;
        end else begin
          m_out <= ref_op(ALUControlE, SrcAE, SrcBE);
          m_zero <= ref_op(ALUControlE, SrcAE, SrcBE) == 0;
          m_ill <= !is_legal(ALUControlE);
          m_valid <= 1;
        end
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      chk("busy", BusyE, m_mul ? (m_k != 1 || StallM) : (ValidE && ALUControlE == 4'b1000 && !FlushE));
      chk("aluout", ALUOutM, m_out);
      chk("zero", ZeroM, m_zero);
      chk("valid", ValidM, m_valid);
      chk("illegal", IllegalOpM, m_ill);
    end
  end

  task automatic step(input logic v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic st, input logic fl);
    ValidE = v; ALUControlE = op; SrcAE = a; SrcBE = b; StallM = st; FlushE = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, busy;
    @(posedge clk);
    #1;
    rst = 0;
    started = 1;
    chk("rst_out", ALUOutM, 0);
    chk("rst_valid", ValidM, 0);
    chk("rst_zero", ZeroM, 0);
    chk("rst_ill", IllegalOpM, 0);
    chk("rst_busy", BusyE, 0);
    step(1, 4'b0010, 5, 7, 0, 0);
    chk("add", ALUOutM, 12); chk("add_valid", ValidM, 1); chk("add_zero", ZeroM, 0);
    step(1, 4'b0110, 9, 9, 0, 0);
    chk("sub", ALUOutM, 0); chk("sub_zero", ZeroM, 1);
    step(1, 4'b0111, 32'hFFFF_FFFF, 1, 0, 0);
    chk("slt_neg", ALUOutM, 1);
    step(1, 4'b0111, 1, 32'hFFFF_FFFF, 0, 0);
    chk("slt_pos", ALUOutM, 0);
    step(1, 4'b0000, 32'hF0F0, 32'hFF00, 0, 0);
    chk("and", ALUOutM, 32'hF000);
    step(1, 4'b0001, 32'hF0F0, 32'hFF00, 0, 0);
    chk("or", ALUOutM, 32'hFFF0);
    ValidE = 1; ALUControlE = 4'b1000; SrcAE = 6; SrcBE = 7;
    n = 0; busy = 0;
    do begin
      @(negedge clk);
      if (BusyE) busy++;
      @(posedge clk);
      #1;
      n++;
    end while (!ValidM && n < 40);
    ValidE = 0;
    chk("mul_edges", n, 33);
    chk("mul_busy_cycles", busy, 32);
    chk("mul67", ALUOutM, 42);
    chk("mul67_valid", ValidM, 1);
    step(0, 4'b0000, 0, 0, 0, 0);
    step(1, 4'b1000, 32'hFFFF_FFFF, 2, 0, 0);
    repeat (32) step(0, 4'b0000, 0, 0, 0, 0);
    chk("mul_wrap", ALUOutM, 32'hFFFF_FFFE);
    chk("mul_wrap_valid", ValidM, 1);
    step(1, 4'b1000, 3, 5, 0, 0);
    repeat (31) step(0, 4'b0000, 0, 0, 0, 0);
    repeat (4) begin
      step(0, 4'b0000, 0, 0, 1, 0);
      chk("stall_busy", BusyE, 1);
      chk("stall_valid", ValidM, 0);
      chk("stall_out", ALUOutM, 32'hFFFF_FFFE);
    end
    step(0, 4'b0000, 0, 0, 0, 0);
    chk("mul35", ALUOutM, 15);
    chk("mul35_valid", ValidM, 1);
    step(1, 4'b1000, 6, 7, 0, 0);
    repeat (10) step(0, 4'b0000, 0, 0, 0, 0);
    step(0, 4'b0000, 0, 0, 0, 1);
    chk("flush_busy", BusyE, 0);
    chk("flush_valid", ValidM, 0);
    step(1, 4'b0010, 1, 2, 0, 0);
    chk("post_flush_add", ALUOutM, 3);
    step(1, 4'b1000, 6, 7, 0, 0);
    repeat (5) step(0, 4'b0000, 0, 0, 0, 0);
    rst = 1;
    step(0, 4'b0000, 0, 0, 0, 0);
    rst = 0;
    chk("mrst_out", ALUOutM, 0);
    chk("mrst_valid", ValidM, 0);
    chk("mrst_busy", BusyE, 0);
    step(1, 4'b0010, 20, 22, 0, 0);
    chk("post_rst_add", ALUOutM, 42);
    chk("post_rst_valid", ValidM, 1);
    step(1, 4'b1111, 3, 4, 0, 0);
    chk("ill_out", ALUOutM, 0); chk("ill_zero", ZeroM, 1);
    chk("ill_flag", IllegalOpM, 1); chk("ill_valid", ValidM, 1);
    step(1, 4'b0010, 1, 1, 0, 0);
    chk("ill_clear", IllegalOpM, 0);
    chk("ill_clear_out", ALUOutM, 2);
    step(0, 4'b0000, 0, 0, 0, 0);
    step(0, 4'b0000, 0, 0, 0, 0);
    started = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
